// File: rtl/gamepad_poller_pkg.sv
// Shared definitions for the gamepad poller: register map, CTRL bit layout,
// poll sequencer state encoding and the stored control word.
package gamepad_poller_pkg;

  localparam int unsigned HOST_AW      = 3;
  localparam int unsigned HOST_DW      = 16;
  localparam int unsigned STATUS_PAD_W = 4;

  localparam int unsigned GP_REG_CTRL = 0;
  localparam int unsigned GP_REG_PAD0 = 1;

  localparam int unsigned CTRL_AUTO_BIT    = 0;
  localparam int unsigned CTRL_M_LATCH_BIT = 1;
  localparam int unsigned CTRL_M_CLK_BIT   = 2;
  localparam int unsigned CTRL_START_BIT   = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LATCH   = 3'd1,
    ST_LOW     = 3'd2,
    ST_HIGH    = 3'd3,
    ST_PUBLISH = 3'd4
  } gp_state_e;

  // Persistent CTRL bits; START is a strobe and is never stored.
  typedef struct packed {
    logic m_clk;
    logic m_latch;
    logic auto_en;
  } gp_ctrl_t;

  function automatic gp_ctrl_t ctrl_from_word(input logic [HOST_DW-1:0] w);
    gp_ctrl_t c;
    c.auto_en = w[CTRL_AUTO_BIT];
    c.m_latch = w[CTRL_M_LATCH_BIT];
    c.m_clk   = w[CTRL_M_CLK_BIT];
    return c;
  endfunction

endpackage

// File: rtl/gamepad_poller_if.sv
// Peripheral host bus between the CPU side and the gamepad poller.
interface gamepad_poller_if;
  import gamepad_poller_pkg::*;

  logic [HOST_AW-1:0] host_address;
  logic               host_write_en;
  logic [HOST_DW-1:0] host_write_data;
  logic               host_read_en;
  logic [HOST_DW-1:0] host_read_data;

  modport master (
    output host_address, host_write_en, host_write_data, host_read_en,
    input  host_read_data
  );

  modport slave (
    input  host_address, host_write_en, host_write_data, host_read_en,
    output host_read_data
  );
endinterface

// File: rtl/gamepad_poller_pad_phase_timer.sv
// Loadable down-counter timing the latch and pad-clock phases; tc_c is high
// while the count sits at zero, i.e. on the last cycle of the loaded phase.
module pad_phase_timer #(
  parameter int unsigned CLK_DIV = 96
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           load,
  input  logic [$clog2(2*CLK_DIV)-1:0]   load_val,
  output logic                           tc_c
);
  localparam int unsigned CW = $clog2(2*CLK_DIV);

  logic [CW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_c = (cnt_q == '0);

endmodule

// File: rtl/gamepad_poller.sv
// Serial gamepad controller: manual or sequenced latch/clock of up to four
// shift-register pads, with atomically published button words on the host bus.
module gamepad_poller
  import gamepad_poller_pkg::*;
#(
  parameter int unsigned PAD_COUNT = 2,
  parameter int unsigned PAD_BITS  = 16,
  parameter int unsigned CLK_DIV   = 96
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 poll_start,
  gamepad_poller_if.slave      host,
  output logic                 pad_latch,
  output logic                 pad_clk,
  input  logic [PAD_COUNT-1:0] pad_data,
  output logic                 busy,
  output logic                 poll_done
);

  localparam int unsigned TW = $clog2(2*CLK_DIV);
  localparam int unsigned BW = (PAD_BITS > 1) ? $clog2(PAD_BITS) : 1;
  localparam logic [TW-1:0] LATCH_LD = TW'(2*CLK_DIV - 1);
  localparam logic [TW-1:0] PHASE_LD = TW'(CLK_DIV - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(PAD_BITS - 1);

  gp_state_e          state_d, state_q;
  gp_ctrl_t           ctrl_d, ctrl_q;
  logic [BW-1:0]      bit_cnt_d, bit_cnt_q;
  logic               done_sticky_d, done_sticky_q;
  logic               busy_d, busy_q;
  logic               poll_done_d, poll_done_q;
  logic               pad_latch_d, pad_latch_q;
  logic               pad_clk_d, pad_clk_q;
  logic [HOST_DW-1:0] read_data_d, read_data_q;

  logic               wr_ctrl_c, trigger_c, status_rd_c;
  logic               tmr_load_c, tmr_tc_c, sample_c, publish_c;
  logic [TW-1:0]      tmr_val_c;
  logic [HOST_DW-1:0] status_c, rd_word_c;
  logic [PAD_COUNT-1:0][HOST_DW-1:0] word_ext;

  assign wr_ctrl_c   = host.host_write_en && (host.host_address == HOST_AW'(GP_REG_CTRL));
  assign status_rd_c = host.host_read_en  && (host.host_address == HOST_AW'(GP_REG_CTRL));
  // Software START and an enabled frame pulse in the same cycle merge into one poll.
  assign trigger_c   = (wr_ctrl_c && host.host_write_data[CTRL_START_BIT])
                     || (poll_start && ctrl_q.auto_en);
  assign publish_c   = (state_q == ST_PUBLISH);

  pad_phase_timer #(.CLK_DIV(CLK_DIV)) u_phase_timer (
    .clk      (clk),
    .resetn   (resetn),
    .load     (tmr_load_c),
    .load_val (tmr_val_c),
    .tc_c     (tmr_tc_c)
  );

  // Poll sequencer next state; triggers outside IDLE are dropped.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    tmr_load_c = 1'b0;
    tmr_val_c  = PHASE_LD;
    sample_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (trigger_c) begin
          state_d    = ST_LATCH;
          tmr_load_c = 1'b1;
          tmr_val_c  = LATCH_LD;
          bit_cnt_d  = '0;
        end
      end
      ST_LATCH: begin
        if (tmr_tc_c) begin
          state_d    = ST_LOW;
          tmr_load_c = 1'b1;
        end
      end
      ST_LOW: begin
        if (tmr_tc_c) begin
          state_d    = ST_HIGH;
          tmr_load_c = 1'b1;
          sample_c   = 1'b1;
        end
      end
      ST_HIGH: begin
        if (tmr_tc_c) begin
          if (bit_cnt_q == LAST_BIT) begin
            state_d = ST_PUBLISH;
          end else begin
            state_d    = ST_LOW;
            tmr_load_c = 1'b1;
            bit_cnt_d  = bit_cnt_q + BW'(1);
          end
        end
      end
      ST_PUBLISH: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Registered pins and flags decoded from the next state.
  always_comb begin
    ctrl_d        = ctrl_q;
    done_sticky_d = done_sticky_q;
    if (wr_ctrl_c) begin
      ctrl_d = ctrl_from_word(host.host_write_data);
    end
    if (publish_c) begin
      done_sticky_d = 1'b1;
    end else if (status_rd_c) begin
      done_sticky_d = 1'b0;
    end
    busy_d      = (state_d == ST_LATCH) || (state_d == ST_LOW) || (state_d == ST_HIGH);
    poll_done_d = (state_d == ST_PUBLISH);
    pad_latch_d = (state_d == ST_IDLE) ? ctrl_d.m_latch : (state_d == ST_LATCH);
    pad_clk_d   = (state_d == ST_IDLE) ? ctrl_d.m_clk   : (state_d != ST_LOW);
  end

  // Per-pad shadow shift capture and visible word, swapped in on PUBLISH.
  for (genvar p = 0; p < int'(PAD_COUNT); p++) begin : g_pad
    logic [PAD_BITS-1:0] shadow_d, shadow_q;
    logic [PAD_BITS-1:0] word_d, word_q;

    always_comb begin
      shadow_d = shadow_q;
      word_d   = word_q;
      if (sample_c) begin
        shadow_d[bit_cnt_q] = ~pad_data[p];
      end
      if (publish_c) begin
        word_d = shadow_q;
      end
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        shadow_q <= '0;
        word_q   <= '0;
      end else begin
        shadow_q <= shadow_d;
        word_q   <= word_d;
      end
    end

    assign word_ext[p] = HOST_DW'(word_q);
  end

  // Host read mux; data holds between read strobes.
  always_comb begin
    status_c  = {8'b0, STATUS_PAD_W'(pad_data), 1'b0, done_sticky_q, busy_q, ctrl_q.auto_en};
    rd_word_c = '0;
    if (host.host_address == HOST_AW'(GP_REG_CTRL)) begin
      rd_word_c = status_c;
    end else begin
      for (int p = 0; p < int'(PAD_COUNT); p++) begin
        if (host.host_address == HOST_AW'(int'(GP_REG_PAD0) + p)) begin
          rd_word_c = word_ext[p];
        end
      end
    end
    read_data_d = read_data_q;
    if (host.host_read_en) begin
      read_data_d = rd_word_c;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      ctrl_q        <= '{m_clk: 1'b1, m_latch: 1'b0, auto_en: 1'b0};
      bit_cnt_q     <= '0;
      done_sticky_q <= 1'b0;
      busy_q        <= 1'b0;
      poll_done_q   <= 1'b0;
      pad_latch_q   <= 1'b0;
      pad_clk_q     <= 1'b1;
      read_data_q   <= '0;
    end else begin
      state_q       <= state_d;
      ctrl_q        <= ctrl_d;
      bit_cnt_q     <= bit_cnt_d;
      done_sticky_q <= done_sticky_d;
      busy_q        <= busy_d;
      poll_done_q   <= poll_done_d;
      pad_latch_q   <= pad_latch_d;
      pad_clk_q     <= pad_clk_d;
      read_data_q   <= read_data_d;
    end
  end

  assign pad_latch           = pad_latch_q;
  assign pad_clk             = pad_clk_q;
  assign busy                = busy_q;
  assign poll_done           = poll_done_q;
  assign host.host_read_data = read_data_q;

endmodule

// File: tb/tb_gamepad_poller.sv
// Directed bench for gamepad_poller: two instances (2x16 bits/div 4 and
// 4x12 bits/div 2) driven by behavioural shift-register pad models.
module tb_gamepad_poller;

  logic clk;
  logic resetn;
  int   total = 0;
  int   bad   = 0;

  gamepad_poller_if host_a ();
  gamepad_poller_if host_b ();

  logic        poll_start_a, poll_start_b;
  logic        latch_a, pclk_a, busy_a, done_a;
  logic        latch_b, pclk_b, busy_b, done_b;
  logic [1:0]  pad_data_a;
  logic [3:0]  pad_data_b;

  logic [15:0] mw_a [2];
  logic [11:0] mw_b [4];
  logic [15:0] sr_a [2] = '{16'hFFFF, 16'hFFFF};
  logic [11:0] sr_b [4] = '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};
  logic        pclk_a_prev = 1'b1, pclk_b_prev = 1'b1;
  logic        ovr_en;
  logic [1:0]  ovr_val;

  int done_cnt_a = 0, done_cnt_b = 0, rise_cnt_a = 0;
  logic busy_a_prev = 1'b0;

  gamepad_poller #(.PAD_COUNT(2), .PAD_BITS(16), .CLK_DIV(4)) dut_a (
    .clk(clk), .resetn(resetn), .poll_start(poll_start_a), .host(host_a),
    .pad_latch(latch_a), .pad_clk(pclk_a), .pad_data(pad_data_a),
    .busy(busy_a), .poll_done(done_a)
  );

  gamepad_poller #(.PAD_COUNT(4), .PAD_BITS(12), .CLK_DIV(2)) dut_b (
    .clk(clk), .resetn(resetn), .poll_start(poll_start_b), .host(host_b),
    .pad_latch(latch_b), .pad_clk(pclk_b), .pad_data(pad_data_b),
    .busy(busy_b), .poll_done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pad models: latch loads the active-low word, each rising pad clock shifts.
  always @(posedge clk) begin
    pclk_a_prev <= pclk_a;
    pclk_b_prev <= pclk_b;
    for (int p = 0; p < 2; p++) begin
      if (latch_a) sr_a[p] <= ~mw_a[p];
      else if (pclk_a && !pclk_a_prev) sr_a[p] <= {1'b1, sr_a[p][15:1]};
    end
    for (int p = 0; p < 4; p++) begin
      if (latch_b) sr_b[p] <= ~mw_b[p];
      else if (pclk_b && !pclk_b_prev) sr_b[p] <= {1'b1, sr_b[p][11:1]};
    end
  end

  assign pad_data_a = ovr_en ? ovr_val : {sr_a[1][0], sr_a[0][0]};
  assign pad_data_b = {sr_b[3][0], sr_b[2][0], sr_b[1][0], sr_b[0][0]};

  always @(posedge clk) begin
    if (done_a) done_cnt_a++;
    if (done_b) done_cnt_b++;
    if (busy_a && !busy_a_prev) rise_cnt_a++;
    busy_a_prev <= busy_a;
  end

  task automatic check(input string nm, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic host_write(input bit sel, input logic [2:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    if (sel) begin host_b.host_address = a; host_b.host_write_data = d; host_b.host_write_en = 1'b1; end
    else     begin host_a.host_address = a; host_a.host_write_data = d; host_a.host_write_en = 1'b1; end
    @(posedge clk); #1;
    host_a.host_write_en = 1'b0;
    host_b.host_write_en = 1'b0;
  endtask

  task automatic host_read(input bit sel, input logic [2:0] a, output logic [15:0] d);
    @(posedge clk); #1;
    if (sel) begin host_b.host_address = a; host_b.host_read_en = 1'b1; end
    else     begin host_a.host_address = a; host_a.host_read_en = 1'b1; end
    @(posedge clk); #1;
    host_a.host_read_en = 1'b0;
    host_b.host_read_en = 1'b0;
    d = sel ? host_b.host_read_data : host_a.host_read_data;
  endtask

  // Counts busy-high samples over a fixed window starting right now.
  task automatic measure_busy(input bit sel, input int window, output int bc);
    bc = 0;
    for (int i = 0; i < window; i++) begin
      if (sel ? busy_b : busy_a) bc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_a;
    @(posedge clk); #1; poll_start_a = 1'b1;
    @(posedge clk); #1; poll_start_a = 1'b0;
  endtask

  typedef struct packed {
    logic        sel;
    logic [2:0]  addr;
    logic [15:0] exp;
  } rd_vec_t;

  rd_vec_t vec [14];

  initial begin
    int bc, d0, r0, p_idx, first_new, partial;
    logic [15:0] rd;

    vec[0]  = '{1'b0, 3'd1, 16'h5A3C};
    vec[1]  = '{1'b0, 3'd2, 16'h0001};
    vec[2]  = '{1'b0, 3'd3, 16'h0000};
    vec[3]  = '{1'b0, 3'd7, 16'h0000};
    vec[4]  = '{1'b0, 3'd0, 16'h0034};
    vec[5]  = '{1'b0, 3'd0, 16'h0030};
    vec[6]  = '{1'b1, 3'd1, 16'h0ABC};
    vec[7]  = '{1'b1, 3'd2, 16'h0123};
    vec[8]  = '{1'b1, 3'd3, 16'h0800};
    vec[9]  = '{1'b1, 3'd4, 16'h0FFF};
    vec[10] = '{1'b1, 3'd5, 16'h0000};
    vec[11] = '{1'b1, 3'd0, 16'h00F4};
    vec[12] = '{1'b1, 3'd0, 16'h00F0};
    vec[13] = '{1'b1, 3'd7, 16'h0000};

    mw_a[0] = 16'h5A3C; mw_a[1] = 16'h0001;
    mw_b[0] = 12'hABC;  mw_b[1] = 12'h123; mw_b[2] = 12'h800; mw_b[3] = 12'hFFF;
    ovr_en = 1'b0; ovr_val = 2'b00;
    poll_start_a = 1'b0; poll_start_b = 1'b0;
    host_a.host_address = '0; host_a.host_write_en = 1'b0; host_a.host_write_data = '0; host_a.host_read_en = 1'b0;
    host_b.host_address = '0; host_b.host_write_en = 1'b0; host_b.host_write_data = '0; host_b.host_read_en = 1'b0;

    // Reset state
    resetn = 1'b1;
    #2 resetn = 1'b0;
    #1;
    check("rst_latch_a", 16'(latch_a), 16'h0);
    check("rst_clk_a",   16'(pclk_a),  16'h1);
    check("rst_busy_a",  16'(busy_a),  16'h0);
    check("rst_done_a",  16'(done_a),  16'h0);
    check("rst_rdata_a", host_a.host_read_data, 16'h0);
    check("rst_clk_b",   16'(pclk_b),  16'h1);
    wait_cycles(3);
    resetn = 1'b1;
    wait_cycles(2);

    // Software START poll on A: 8 + 128 busy cycles, one publish
    host_write(1'b0, 3'd0, 16'h0008);
    check("start_latch_a", 16'(latch_a), 16'h1);
    measure_busy(1'b0, 300, bc);
    check("busy_len_a", 16'(bc), 16'd136);
    check("done_cnt_a", 16'(done_cnt_a), 16'd1);

    // B: 4 pads x 12 bits, CLK_DIV 2 -> 52 busy cycles
    host_write(1'b1, 3'd0, 16'h0008);
    measure_busy(1'b1, 150, bc);
    check("busy_len_b", 16'(bc), 16'd52);
    check("done_cnt_b", 16'(done_cnt_b), 16'd1);

    for (int i = 0; i < 14; i++) begin
      host_read(vec[i].sel, vec[i].addr, rd);
      check($sformatf("rd_vec%0d", i), rd, vec[i].exp);
    end

    // Manual pins and raw STATUS pad bits; writes to pad registers ignored
    host_write(1'b0, 3'd0, 16'h0006);
    check("man_latch", 16'(latch_a), 16'h1);
    check("man_clk",   16'(pclk_a),  16'h1);
    ovr_en = 1'b1; ovr_val = 2'b10;
    host_read(1'b0, 3'd0, rd);
    check("man_status", rd, 16'h0020);
    ovr_en = 1'b0;
    host_write(1'b0, 3'd1, 16'hFFFF);
    host_read(1'b0, 3'd1, rd);
    check("ro_pad_reg", rd, 16'h5A3C);
    host_write(1'b0, 3'd0, 16'h0004);

    // Frame pulses: ignored without AUTO; with AUTO one poll per pulse,
    // a mid-poll pulse is dropped, clearing AUTO mid-poll still completes
    pulse_a;
    wait_cycles(10);
    check("noauto_busy", 16'(busy_a), 16'h0);
    host_write(1'b0, 3'd0, 16'h0005);
    d0 = done_cnt_a; r0 = rise_cnt_a;
    for (int k = 0; k < 3; k++) begin
      pulse_a;
      wait_cycles(50);
      if (k == 1) pulse_a;
      if (k == 2) host_write(1'b0, 3'd0, 16'h0004);
      wait_cycles(150);
    end
    check("auto_done", 16'(done_cnt_a - d0), 16'd3);
    check("auto_rise", 16'(rise_cnt_a - r0), 16'd3);

    // Atomic publish: continuous reads of pad 0 never show a partial word
    mw_a[0] = 16'h1234;
    host_write(1'b0, 3'd0, 16'h000C);
    host_a.host_address = 3'd1; host_a.host_read_en = 1'b1;
    p_idx = -100; first_new = -1; partial = 0;
    for (int i = 0; i < 200; i++) begin
      if (i == 20) mw_a[0] = 16'hFFFF;
      if (done_a) p_idx = i;
      if (i >= 1) begin
        if (host_a.host_read_data == 16'h1234 && first_new < 0) first_new = i;
        if (host_a.host_read_data != 16'h5A3C && host_a.host_read_data != 16'h1234) partial++;
      end
      @(posedge clk); #1;
    end
    host_a.host_read_en = 1'b0;
    check("atomic_partial", 16'(partial), 16'd0);
    check("atomic_switch", 16'(first_new), 16'(p_idx + 2));

    // Reset in the middle of a poll
    host_write(1'b0, 3'd0, 16'h000C);
    d0 = done_cnt_a;
    wait_cycles(50);
    resetn = 1'b0;
    #1;
    check("mid_rst_latch", 16'(latch_a), 16'h0);
    check("mid_rst_clk",   16'(pclk_a),  16'h1);
    check("mid_rst_busy",  16'(busy_a),  16'h0);
    wait_cycles(3);
    resetn = 1'b1;
    wait_cycles(2);
    host_read(1'b0, 3'd1, rd);
    check("mid_rst_w1", rd, 16'h0);
    host_read(1'b0, 3'd2, rd);
    check("mid_rst_w2", rd, 16'h0);
    host_read(1'b1, 3'd1, rd);
    check("mid_rst_b1", rd, 16'h0);
    host_read(1'b0, 3'd0, rd);
    check("mid_rst_stat", rd & 16'h000F, 16'h0);
    check("mid_rst_nodone", 16'(done_cnt_a - d0), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
